// File: rtl/fp_div_pkg.sv
// Shared widths, state and class encodings, and field helpers for the
// single-precision sequential SRT divider.
package fp_div_pkg;

  localparam int unsigned FP_WIDTH   = 32;
  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned MANT_WIDTH = 23;
  localparam int unsigned BIAS       = 127;
  localparam int unsigned ITERS      = 25;

  // Significand with hidden bit, quotient, remainder, divisor and exponent widths.
  localparam int unsigned SIG_W  = MANT_WIDTH + 1;
  localparam int unsigned Q_W    = ITERS;
  localparam int unsigned REM_W  = SIG_W + 3;
  localparam int unsigned DV_W   = SIG_W + 1;
  localparam int unsigned EXPI_W = EXP_WIDTH + 2;
  localparam int unsigned CNT_W  = $clog2(ITERS);

  localparam int unsigned EXP_MAX = (1 << EXP_WIDTH) - 1;

  localparam logic [FP_WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    NORM,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] frac;
    fp_class_e             cls;
  } fp_unpacked_t;

  // Split a float into fields; subnormals are classed as zero (flushed).
  function automatic fp_unpacked_t fp_unpack(input logic [FP_WIDTH-1:0] x);
    fp_unpacked_t u;
    u.sign = x[FP_WIDTH-1];
    u.exp  = x[FP_WIDTH-2 -: EXP_WIDTH];
    u.frac = x[MANT_WIDTH-1:0];
    if (u.exp == '0) begin
      u.cls = CLS_ZERO;
    end else if (u.exp == '1) begin
      u.cls = (u.frac == '0) ? CLS_INF : CLS_NAN;
    end else begin
      u.cls = CLS_NORM;
    end
    return u;
  endfunction

  function automatic logic [FP_WIDTH-1:0] fp_inf(input logic sign);
    return {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  endfunction

  function automatic logic [FP_WIDTH-1:0] fp_zero(input logic sign);
    return {sign, {(FP_WIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/srt_r2_step.sv
// One combinational radix-2 SRT step.
//  rem      in   REM_W  partial remainder (two's complement)
//  dv       in   DV_W   divisor, scaled so the selection thresholds are +-2^SIG_W
//  q, qm    in   Q_W    on-the-fly quotient Q and Q-1
//  rem_next out  REM_W  2*rem - digit*dv
//  q_next   out  Q_W    updated Q
//  qm_next  out  Q_W    updated Q-1
module srt_r2_step
  import fp_div_pkg::*;
(
  input  logic signed [REM_W-1:0] rem,
  input  logic        [DV_W-1:0]  dv,
  input  logic        [Q_W-1:0]   q,
  input  logic        [Q_W-1:0]   qm,
  output logic signed [REM_W-1:0] rem_next,
  output logic        [Q_W-1:0]   q_next,
  output logic        [Q_W-1:0]   qm_next
);

  logic signed [REM_W-1:0] two_r;
  logic signed [REM_W-1:0] dvx;
  logic        [2:0]       top;
  logic                    pos;
  logic                    neg;

  // Digit from the top three bits of 2r: +1 if 2r >= 1/2, -1 if 2r < -1/2, else 0.
  always_comb begin
    two_r = rem <<< 1;
    dvx   = $signed({{(REM_W-DV_W){1'b0}}, dv});
    top   = two_r[REM_W-1 -: 3];
    pos   = !top[2] && (top[1:0] != 2'b00);
    neg   = top[2] && (top[1:0] != 2'b11);

    rem_next = two_r;
    q_next   = q << 1;
    qm_next  = (qm << 1) | Q_W'(1);
    if (pos) begin
      rem_next = two_r - dvx;
      q_next   = (q << 1) | Q_W'(1);
      qm_next  = q << 1;
    end else if (neg) begin
      rem_next = two_r + dvx;
      q_next   = (qm << 1) | Q_W'(1);
      qm_next  = qm << 1;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequencing controller for the single-precision SRT divider.
//  clk, rst_n          clock (rising edge), async active-low reset
//  in_valid/in_ready   operand handshake; in_ready high only when idle
//  dividend, divisor   IEEE-754 operands, captured on the accept edge
//  out_valid/out_ready result handshake; result and flags held until consumed
//  result              truncated quotient (subnormal inputs/outputs flushed to zero)
//  div_zero            finite nonzero / zero
//  invalid             0/0, inf/inf or any NaN operand
// The first SRT step is folded into PREP, so ITER runs with cnt = 1..ITERS-1.
module fp_div_seq
  import fp_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] dividend,
  input  logic [FP_WIDTH-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] result,
  output logic                div_zero,
  output logic                invalid
);

  state_e                   state, state_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [FP_WIDTH-1:0]      op_a, op_a_d;
  logic [FP_WIDTH-1:0]      op_b, op_b_d;
  logic                     sign_r, sign_d;
  logic [EXPI_W-1:0]        exp_r, exp_d;
  logic signed [REM_W-1:0]  rem_r, rem_d;
  logic [DV_W-1:0]          dv_r, dv_d;
  logic [Q_W-1:0]           q_r, q_d;
  logic [Q_W-1:0]           qm_r, qm_d;
  logic [FP_WIDTH-1:0]      result_d;
  logic                     div_zero_d, invalid_d;
  logic                     out_valid_d, in_ready_d;

  fp_unpacked_t             ua, ub;
  logic signed [REM_W-1:0]  rem_in, rem_step;
  logic [DV_W-1:0]          dv_in;
  logic [Q_W-1:0]           q_in, qm_in, q_step, qm_step;

  // Step operands: fresh significands in PREP, loop registers afterwards.
  always_comb begin
    ua = fp_unpack(op_a);
    ub = fp_unpack(op_b);
    if (state == PREP) begin
      rem_in = {{(REM_W-SIG_W){1'b0}}, 1'b1, ua.frac};
      dv_in  = {1'b1, ub.frac, 1'b0};
      q_in   = '0;
      qm_in  = '1;
    end else begin
      rem_in = rem_r;
      dv_in  = dv_r;
      q_in   = q_r;
      qm_in  = qm_r;
    end
  end

  srt_r2_step u_step (
    .rem      (rem_in),
    .dv       (dv_in),
    .q        (q_in),
    .qm       (qm_in),
    .rem_next (rem_step),
    .q_next   (q_step),
    .qm_next  (qm_step)
  );

  logic                  s_c;
  logic [Q_W-1:0]        qf;
  logic [EXPI_W-1:0]     exp_n;
  logic [MANT_WIDTH-1:0] frac_n;

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_a_d     = op_a;
    op_b_d     = op_b;
    sign_d     = sign_r;
    exp_d      = exp_r;
    rem_d      = rem_r;
    dv_d       = dv_r;
    q_d        = q_r;
    qm_d       = qm_r;
    result_d   = result;
    div_zero_d = div_zero;
    invalid_d  = invalid;
    s_c        = ua.sign ^ ub.sign;
    qf         = rem_r[REM_W-1] ? qm_r : q_r;
    exp_n      = qf[Q_W-1] ? exp_r : exp_r - EXPI_W'(1);
    frac_n     = qf[Q_W-1] ? qf[Q_W-2:1] : qf[Q_W-3:0];

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_a_d     = dividend;
          op_b_d     = divisor;
          div_zero_d = 1'b0;
          invalid_d  = 1'b0;
          cnt_d      = '0;
          state_d    = PREP;
        end
      end
      PREP: begin
        sign_d = s_c;
        exp_d  = {2'b00, ua.exp} - {2'b00, ub.exp} + EXPI_W'(BIAS);
        if (ua.cls == CLS_NAN || ub.cls == CLS_NAN ||
            (ua.cls == CLS_ZERO && ub.cls == CLS_ZERO) ||
            (ua.cls == CLS_INF && ub.cls == CLS_INF)) begin
          result_d  = QNAN;
          invalid_d = 1'b1;
          state_d   = DONE;
        end else if (ub.cls == CLS_ZERO) begin
          result_d   = fp_inf(s_c);
          div_zero_d = (ua.cls == CLS_NORM);
          state_d    = DONE;
        end else if (ua.cls == CLS_INF) begin
          result_d = fp_inf(s_c);
          state_d  = DONE;
        end else if (ua.cls == CLS_ZERO || ub.cls == CLS_INF) begin
          result_d = fp_zero(s_c);
          state_d  = DONE;
        end else begin
          rem_d   = rem_step;
          dv_d    = dv_in;
          q_d     = q_step;
          qm_d    = qm_step;
          cnt_d   = CNT_W'(1);
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = rem_step;
        q_d   = q_step;
        qm_d  = qm_step;
        if (cnt == CNT_W'(ITERS-1)) begin
          cnt_d   = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      NORM: begin
        // Negative final remainder selects Q-1; then normalize, truncate, range-check.
        if (exp_n[EXPI_W-1] || exp_n == '0) begin
          result_d = fp_zero(sign_r);
        end else if (exp_n >= EXPI_W'(EXP_MAX)) begin
          result_d = fp_inf(sign_r);
        end else begin
          result_d = {sign_r, exp_n[EXP_WIDTH-1:0], frac_n};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      rem_r     <= '0;
      dv_r      <= '0;
      q_r       <= '0;
      qm_r      <= '0;
      result    <= '0;
      div_zero  <= 1'b0;
      invalid   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
      sign_r    <= sign_d;
      exp_r     <= exp_d;
      rem_r     <= rem_d;
      dv_r      <= dv_d;
      q_r       <= q_d;
      qm_r      <= qm_d;
      result    <= result_d;
      div_zero  <= div_zero_d;
      invalid   <= invalid_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vector table, hold/reset
// sequences, and random operands against an integer-arithmetic reference.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_zero;
  logic        invalid;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero),
    .invalid   (invalid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Reference: IEEE classes with subnormal flush, truncated quotient via integer division.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz,
                                output logic inv, output int lat);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint unsigned ma, mb, m;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    a_zero = (ea == 8'd0);  b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    dz = 1'b0; inv = 1'b0; lat = 2;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r = 32'h7FC00000; inv = 1'b1;
    end else if (b_zero) begin
      r = {s, 8'hFF, 23'd0}; dz = !a_inf;
    end else if (a_inf) begin
      r = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      r = {s, 31'd0};
    end else begin
      lat = 27;
      ma = 64'(1 << 23) | 64'(fa);
      mb = 64'(1 << 23) | 64'(fb);
      e  = int'(ea) - int'(eb) + 127;
      if (ma >= mb) begin
        m = (ma << 23) / mb;
      end else begin
        m = (ma << 24) / mb;
        e = e - 1;
      end
      if (e >= 255)     r = {s, 8'hFF, 23'd0};
      else if (e <= 0)  r = {s, 31'd0};
      else              r = {s, 8'(e), m[22:0]};
    end
  endfunction

  // Accept one operand pair, wait for the result, then consume it after 'hold' cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output logic [31:0] r, output logic dz, output logic inv,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    r = result; dz = div_zero; inv = invalid;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    int          sel;
    x   = $urandom;
    sel = int'($urandom_range(0, 15));
    case (sel)
      0: x[30:23] = 8'd0;
      1: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
      2: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
      3: x[30:23] = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
      4, 5, 6, 7: x[30:23] = 8'($urandom_range(1, 254));
      default: x[30:23] = 8'($urandom_range(100, 154));
    endcase
    return x;
  endfunction

  logic [31:0] r, er;
  logic        dz, inv, edz, einv;
  int          lat, elat;
  logic        bad;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;

    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 2});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 2});
    vecs.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 2});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 2});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2});
    vecs.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0, 2});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h00800000, 32'h3F800001, 32'h00000000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 27});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 2});

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {30'd0, div_zero, invalid}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, i % 3, r, dz, inv, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_div_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d_invalid", i), {31'd0, inv}, {31'd0, vecs[i].inv});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held, in_ready low, new in_valid ignored.
    @(negedge clk);
    dividend = 32'h40C00000; divisor = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_out_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      dividend = 32'h3F800000; divisor = 32'h40400000; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d_result", k), result, 32'h40400000);
      chk($sformatf("hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_release_in_ready",  {31'd0, in_ready},  32'd1);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad = 1'b1;
    end
    chk("hold_no_ghost_op", {31'd0, bad}, 32'd0);

    // Reset mid-iteration drops the operation.
    @(negedge clk);
    dividend = 32'h3F800000; divisor = 32'h40400000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_result",    result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h40C00000, 32'h40000000, 0, r, dz, inv, lat);
    chk("postrst_result",  r,          32'h40400000);
    chk("postrst_latency", 32'(lat),   32'd27);

    // Random operands against the reference.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      a = rnd_fp();
      b = rnd_fp();
      model(a, b, er, edz, einv, elat);
      run_op(a, b, int'($urandom_range(0, 2)), r, dz, inv, lat);
      chk($sformatf("rnd%0d_result_%h_%h", n, a, b), r, er);
      chk($sformatf("rnd%0d_div_zero", n), {31'd0, dz}, {31'd0, edz});
      chk($sformatf("rnd%0d_invalid", n), {31'd0, inv}, {31'd0, einv});
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
